// File: rtl/exbus_pkg.sv
// Shared exbus word definitions: special-word markers, field positions and
// a word classifier used by both the idle inserter and the idle receiver.
package exbus_pkg;

  localparam int EXB_WIDTH = 35;

  // Bits [34:33] mark a special (non-command) word
  localparam logic [1:0] EXB_SPECIAL = 2'b11;
  // Code in [30:28] of a FIFO-error word
  localparam logic [2:0] EXB_FERR    = 3'b011;

  // Field positions inside a special word
  localparam int EXB_AUX_HI   = 32;
  localparam int EXB_AUX_LO   = 31;
  localparam int EXB_IDLE_BIT = 30;
  localparam int EXB_CTS_BIT  = 29;
  localparam int EXB_INT_BIT  = 28;

  typedef enum logic [1:0] {
    EXB_CLS_DATA  = 2'd0,
    EXB_CLS_IDLE  = 2'd1,
    EXB_CLS_FERR  = 2'd2,
    EXB_CLS_OTHER = 2'd3
  } exb_class_t;

  // Decode the kind of a received word
  function automatic exb_class_t exb_classify(input logic [EXB_WIDTH-1:0] word);
    exb_class_t cls;
    if (word[34:33] != EXB_SPECIAL)
      cls = EXB_CLS_DATA;
    else if (word[EXB_IDLE_BIT])
      cls = EXB_CLS_IDLE;
    else if (word[30:28] == EXB_FERR)
      cls = EXB_CLS_FERR;
    else
      cls = EXB_CLS_OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/exrx_watchdog.sv
// Receive watchdog: counts cycles since the last accepted word and pulses
// o_expire for one cycle when the count reaches all-ones, then wraps.
module exrx_watchdog #(
  parameter int LGTIMEOUT = 25
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [LGTIMEOUT-1:0] ONE = LGTIMEOUT'(1);

  logic [LGTIMEOUT-1:0] r_count;

  // An accept on the expiry cycle wins, so expiry never coincides with one
  assign o_expire = !i_clear && (&r_count);

  // Free-running idle-time counter, restarted by every accepted word
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else
      r_count <= r_count + ONE;
  end

endmodule

// File: rtl/exrxidle.sv
// exbus receive idle/status extractor: consumes idle and FIFO-error words,
// forwards everything else, tracks remote status and link sync.
module exrxidle
  import exbus_pkg::*;
#(
  parameter int SYNC_IDLES = 5,
  parameter int LGTIMEOUT  = 25
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stb,
  input  logic [EXB_WIDTH-1:0] i_word,
  input  logic                 i_err,
  output logic                 o_busy,
  output logic                 o_stb,
  output logic [EXB_WIDTH-1:0] o_word,
  input  logic                 i_busy,
  output logic [1:0]           o_aux,
  output logic                 o_cts,
  output logic                 o_int,
  output logic                 o_int_edge,
  output logic                 o_fifo_err,
  output logic                 o_sync
);

  localparam logic       ST_HUNT     = 1'b0;
  localparam logic       ST_SYNC     = 1'b1;
  localparam logic [2:0] SYNC_TARGET = 3'(SYNC_IDLES);

  exb_class_t           w_class;
  logic                 w_accept;
  logic                 w_idle;
  logic                 w_ferr;
  logic                 w_other;
  logic                 w_forward;
  logic                 w_expire;
  logic                 w_drop;
  logic [2:0]           w_idle_inc;

  logic                 r_state;
  logic [2:0]           r_idle_cnt;
  logic                 r_stb;
  logic [EXB_WIDTH-1:0] r_word;
  logic [1:0]           r_aux;
  logic                 r_cts;
  logic                 r_int;
  logic                 r_int_edge;
  logic                 r_fifo_err;

  assign o_busy     = r_stb && i_busy;
  assign w_accept   = i_stb && !o_busy;
  assign w_class    = exb_classify(i_word);
  assign w_idle     = w_accept && (w_class == EXB_CLS_IDLE);
  assign w_ferr     = w_accept && (w_class == EXB_CLS_FERR);
  assign w_other    = w_accept && (w_class == EXB_CLS_OTHER);
  assign w_forward  = w_accept && ((w_class == EXB_CLS_DATA) || (w_class == EXB_CLS_OTHER));
  // Expiry only matters once synchronized; a framing error always restarts the hunt
  assign w_drop     = i_err || ((r_state == ST_SYNC) && w_expire);
  assign w_idle_inc = (r_idle_cnt == 3'd7) ? 3'd7 : r_idle_cnt + 3'd1;

  exrx_watchdog #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_accept),
    .o_expire (w_expire)
  );

  // Output register for forwarded words; holds while downstream stalls
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stb  <= 1'b0;
      r_word <= '0;
    end else if (w_forward) begin
      r_stb  <= 1'b1;
      r_word <= i_word;
    end else if (!i_busy) begin
      r_stb  <= 1'b0;
    end
  end

  // Remote status recovered from idle and other special words
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_aux      <= 2'b00;
      r_cts      <= 1'b0;
      r_int      <= 1'b0;
      r_int_edge <= 1'b0;
      r_fifo_err <= 1'b0;
    end else begin
      r_int_edge <= 1'b0;
      r_fifo_err <= w_ferr;
      if (w_idle || w_ferr || w_other)
        r_aux <= i_word[EXB_AUX_HI:EXB_AUX_LO];
      if (w_idle) begin
        r_cts      <= i_word[EXB_CTS_BIT];
        r_int      <= i_word[EXB_INT_BIT];
        r_int_edge <= i_word[EXB_INT_BIT] && !r_int;
      end else if ((r_state == ST_SYNC) && w_expire) begin
        // Remote has gone quiet: stop trusting its clear-to-send
        r_cts <= 1'b0;
      end
    end
  end

  // Idle-run counter and HUNT/SYNC state; loss of sync has priority
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_HUNT;
      r_idle_cnt <= 3'd0;
    end else if (w_drop) begin
      r_state    <= ST_HUNT;
      r_idle_cnt <= 3'd0;
    end else if (w_idle) begin
      r_idle_cnt <= w_idle_inc;
      if ((r_state == ST_HUNT) && (w_idle_inc == SYNC_TARGET))
        r_state <= ST_SYNC;
    end else if (w_other) begin
      r_idle_cnt <= 3'd0;
    end
  end

  assign o_stb      = r_stb;
  assign o_word     = r_word;
  assign o_aux      = r_aux;
  assign o_cts      = r_cts;
  assign o_int      = r_int;
  assign o_int_edge = r_int_edge;
  assign o_fifo_err = r_fifo_err;
  assign o_sync     = r_state;

endmodule

// File: tb/tb_exrxidle.sv
// Directed testbench for exrxidle with a short watchdog (LGTIMEOUT=6).
module tb_exrxidle;

  localparam logic [34:0] W_IDLE  = 35'h7_6000_0000;
  localparam logic [34:0] W_IDLEI = 35'h7_7000_0000;
  localparam logic [34:0] W_FERR  = 35'h6_3000_0000;
  localparam logic [34:0] W_DATA  = 35'h0_1234_5678;
  localparam logic [34:0] W_DATA2 = 35'h1_0BAD_CAFE;
  localparam logic [34:0] W_OTHER = 35'h7_0000_0001;

  logic        clk = 1'b0;
  logic        i_reset, i_stb, i_err, i_busy;
  logic [34:0] i_word;
  logic        o_busy, o_stb, o_cts, o_int, o_int_edge, o_fifo_err, o_sync;
  logic [34:0] o_word;
  logic [1:0]  o_aux;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exrxidle #(.SYNC_IDLES(5), .LGTIMEOUT(6)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_word(i_word),
    .i_err(i_err), .o_busy(o_busy), .o_stb(o_stb), .o_word(o_word),
    .i_busy(i_busy), .o_aux(o_aux), .o_cts(o_cts), .o_int(o_int),
    .o_int_edge(o_int_edge), .o_fifo_err(o_fifo_err), .o_sync(o_sync)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word for one clock edge (accepted when o_busy is low)
  task automatic send(input logic [34:0] w);
    i_stb  = 1'b1;
    i_word = w;
    tick();
    i_stb  = 1'b0;
    $display("txn word=%h sync=%b stb=%b aux=%b cts=%b int=%b", w, o_sync, o_stb, o_aux, o_cts, o_int);
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_stb = 1'b0; i_err = 1'b0; i_busy = 1'b0; i_word = '0;
    tick(); tick();
    n_vec++;
    if ({o_stb, o_word, o_aux, o_cts, o_int, o_int_edge, o_fifo_err, o_sync, o_busy} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got stb=%b word=%h aux=%b cts=%b int=%b edge=%b ferr=%b sync=%b busy=%b, want all 0",
               o_stb, o_word, o_aux, o_cts, o_int, o_int_edge, o_fifo_err, o_sync, o_busy);
    end
    i_reset = 1'b0;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_sync_acquire;
    for (int k = 1; k <= 5; k++) begin
      send(W_IDLE);
      n_vec++;
      if (o_sync !== (k == 5)) begin
        n_err++; $display("FAIL sync_acquire idle %0d: o_sync=%b want %b", k, o_sync, (k == 5));
      end
      n_vec++;
      if (o_stb !== 1'b0) begin
        n_err++; $display("FAIL idle_not_forwarded %0d: o_stb=%b want 0", k, o_stb);
      end
    end
    n_vec++;
    if ({o_aux, o_cts, o_int} !== 4'b1010) begin
      n_err++; $display("FAIL idle_status: aux=%b cts=%b int=%b want aux=10 cts=1 int=0", o_aux, o_cts, o_int);
    end
  endtask

  task automatic test_busy;
    i_busy = 1'b1;
    i_stb  = 1'b1;
    i_word = W_DATA;
    tick();
    i_word = W_DATA2;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({o_stb, o_busy, o_word} !== {1'b1, 1'b1, W_DATA}) begin
        n_err++; $display("FAIL busy_hold cycle %0d: stb=%b busy=%b word=%h want 1 1 %h", c, o_stb, o_busy, o_word, W_DATA);
      end
      $display("txn busy cycle %0d word=%h", c, o_word);
      if (c < 2) tick();
    end
    i_busy = 1'b0;
    #1;
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++; $display("FAIL busy_release: o_busy=%b want 0", o_busy);
    end
    tick();
    i_stb = 1'b0;
    n_vec++;
    if ({o_stb, o_word} !== {1'b1, W_DATA2}) begin
      n_err++; $display("FAIL second_word: stb=%b word=%h want 1 %h", o_stb, o_word, W_DATA2);
    end
    tick();
    n_vec++;
    if (o_stb !== 1'b0) begin
      n_err++; $display("FAIL stb_drop: o_stb=%b want 0", o_stb);
    end
  endtask

  task automatic test_ferr;
    send(W_FERR);
    n_vec++;
    if ({o_fifo_err, o_aux, o_stb} !== 4'b1000) begin
      n_err++; $display("FAIL ferr_word: ferr=%b aux=%b stb=%b want 1 00 0", o_fifo_err, o_aux, o_stb);
    end
    tick();
    n_vec++;
    if ({o_fifo_err, o_sync} !== 2'b01) begin
      n_err++; $display("FAIL ferr_pulse_end: ferr=%b sync=%b want 0 1", o_fifo_err, o_sync);
    end
  endtask

  task automatic test_int_edge;
    send(W_IDLE);
    n_vec++;
    if ({o_int, o_int_edge} !== 2'b00) begin
      n_err++; $display("FAIL int_low: int=%b edge=%b want 0 0", o_int, o_int_edge);
    end
    send(W_IDLEI);
    n_vec++;
    if ({o_int, o_int_edge} !== 2'b11) begin
      n_err++; $display("FAIL int_rise: int=%b edge=%b want 1 1", o_int, o_int_edge);
    end
    send(W_IDLEI);
    n_vec++;
    if ({o_int, o_int_edge} !== 2'b10) begin
      n_err++; $display("FAIL int_repeat: int=%b edge=%b want 1 0", o_int, o_int_edge);
    end
  endtask

  task automatic test_other_special;
    send(W_OTHER);
    n_vec++;
    if ({o_stb, o_word, o_aux, o_sync} !== {1'b1, W_OTHER, 2'b10, 1'b1}) begin
      n_err++; $display("FAIL other_special: stb=%b word=%h aux=%b sync=%b want 1 %h 10 1", o_stb, o_word, o_aux, o_sync, W_OTHER);
    end
    tick();
  endtask

  task automatic test_err_resync;
    i_err = 1'b1;
    send(W_IDLE);
    i_err = 1'b0;
    n_vec++;
    if (o_sync !== 1'b0) begin
      n_err++; $display("FAIL err_drop: o_sync=%b want 0", o_sync);
    end
    for (int k = 1; k <= 5; k++) begin
      send(W_IDLE);
      n_vec++;
      if (o_sync !== (k == 5)) begin
        n_err++; $display("FAIL resync idle %0d: o_sync=%b want %b", k, o_sync, (k == 5));
      end
    end
  endtask

  task automatic test_watchdog;
    for (int c = 0; c < 63; c++) tick();
    send(W_IDLE);
    n_vec++;
    if ({o_sync, o_cts} !== 2'b11) begin
      n_err++; $display("FAIL wd_rescued: sync=%b cts=%b want 1 1", o_sync, o_cts);
    end
    for (int c = 0; c < 63; c++) tick();
    n_vec++;
    if ({o_sync, o_cts} !== 2'b11) begin
      n_err++; $display("FAIL wd_before_expiry: sync=%b cts=%b want 1 1", o_sync, o_cts);
    end
    tick();
    $display("txn watchdog expiry sync=%b cts=%b", o_sync, o_cts);
    n_vec++;
    if ({o_sync, o_cts} !== 2'b00) begin
      n_err++; $display("FAIL wd_expiry: sync=%b cts=%b want 0 0", o_sync, o_cts);
    end
  endtask

  task automatic test_async_reset;
    send(W_IDLEI);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    n_vec++;
    if ({o_aux, o_cts, o_int} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset: aux=%b cts=%b int=%b want 00 0 0", o_aux, o_cts, o_int);
    end
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync_acquire();
    test_busy();
    test_ferr();
    test_int_edge();
    test_other_special();
    test_err_resync();
    test_watchdog();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exrxidle.md
Name: exrxidle

Overview:
- Receive-side counterpart of the exbus idle/status inserter. Sits between the exbus word decoder and the bus command processor.
- Consumes idle/status and FIFO-error special words and forwards all other 35-bit words downstream.
- Recovers the remote status: aux, CTS, interrupt and FIFO-error events.
- Declares link sync after a run of idle words; drops sync on decoder error or watchdog timeout.

Parameters:
SYNC_IDLES, 5, number of consecutive idle words required before o_sync asserts (1..7).
LGTIMEOUT, 25, log2 of cycles without any received word before sync is dropped. Must exceed the transmitter's LGIDLE.

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_stb  input  1  incoming word valid
i_word  input  35  incoming word
i_err  input  1  decoder framing error (single-cycle pulse)
o_busy  output  1  stall to upstream; equals o_stb && i_busy
o_stb  output  1  forwarded word valid
o_word  output  35  forwarded word
i_busy  input  1  downstream stall
o_aux  output  2  last received remote aux bits
o_cts  output  1  remote clear-to-send
o_int  output  1  remote interrupt level
o_int_edge  output  1  one-cycle pulse on a 0->1 change of o_int
o_fifo_err  output  1  one-cycle pulse per received FIFO-error word
o_sync  output  1  link synchronized

Behaviour:
- One clock. Reset is asynchronous and active-high on i_reset. Every register clears immediately on assertion.
- Reset values: o_stb=0, o_word=0, o_aux=0, o_cts=0, o_int=0, o_int_edge=0, o_fifo_err=0, o_sync=0, idle counter=0, watchdog=0.
- Word accept: accept = i_stb && !o_busy. Upstream holds i_word stable while o_busy.
- Classification of an accepted word (bits [34:33]==2'b11 mark a special word):
  - IDLE: special and [30]==1.
    - o_aux<=[32:31], o_cts<=[29], o_int<=[28].
    - Not forwarded.
    - Idle counter increments, saturating at 7.
  - FERR: special and [30:28]==3'b011.
    - o_aux<=[32:31]; o_fifo_err pulses the next cycle.
    - Not forwarded; idle counter unchanged.
  - OTHER SPECIAL: special and [30]==0 and [30:28]!=3'b011.
    - o_aux<=[32:31]; forwarded unchanged.
    - Idle counter cleared to 0.
  - DATA: [34:33]!=2'b11.
    - Forwarded unchanged; idle counter unchanged.
- Output register: on accept of a forwarded word, o_stb<=1 and o_word<=i_word, latency 1.
  - Else if !i_busy, o_stb<=0.
  - o_word holds while o_stb && i_busy.
- Consumed words are accepted only when !o_busy, so stream order is preserved.
- o_int_edge: registered, high one cycle when an IDLE changes o_int from 0 to 1.
- Sync state machine, two states:
  - HUNT -> SYNC when an IDLE accept brings the counter to SYNC_IDLES.
  - SYNC -> HUNT on i_err or watchdog expiry; this also clears the idle counter.
  - o_sync = (state==SYNC), registered.
- Watchdog: LGTIMEOUT-bit counter.
  - Clears on any accept (including IDLE and FERR); otherwise increments every cycle.
  - On reaching all-ones it raises a one-cycle expiry and wraps to 0.
  - The watchdog runs in HUNT as well, but has no effect there.
  - Expiry also forces o_cts<=0.
- Simultaneous events:
  - i_err on the same cycle as an IDLE accept: i_err wins. State HUNT, counter=0, and this idle is not counted.
  - Expiry on the same cycle as an accept cannot occur, because an accept clears the watchdog first.
- Forwarding does not depend on o_sync; the downstream block gates on o_sync if required.

Decomposition:
- Shared package exbus_pkg holds:
  - EXB_SPECIAL=2'b11, field positions (aux [32:31], idle flag [30], cts [29], int [28]).
  - EXB_FERR=3'b011 and the word width 35.
  - Used by both the transmitter idle inserter and this block.
- One sub-module, exrx_watchdog (parameter LGTIMEOUT): inputs clear, output expiry pulse.

Test Plan:
- Reset, then 5 idle words 35'h7_6000_0000 -> o_sync rises 1 cycle after the 5th accept; o_aux=2'b10, o_cts=1, o_int=0; o_stb never asserts.
- Data 35'h0_1234_5678 with i_busy high 3 cycles -> o_stb=1, o_word stable, o_busy=1 throughout; next word accepted only after i_busy falls.
- FIFO-error word 35'h6_3000_0000 -> o_fifo_err one-cycle pulse, o_aux=2'b00, nothing forwarded.
- Idle 35'h7_6000_0000 followed by 35'h7_7000_0000 (int=1) -> o_int 0->1 and a single o_int_edge pulse; repeating int=1 gives no further pulse.
- In SYNC, i_err asserted on the same cycle as an idle accept -> o_sync=0 next cycle; 5 further idles are needed to re-sync.
- With LGTIMEOUT=6 in SYNC and no input for 64 cycles -> o_sync=0 and o_cts=0 exactly on expiry; one word at cycle 63 prevents the drop.
